// File: rtl/wb_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_skid_if
// Brief    : Handshake, writeback, forwarding and counter bundle for wb_stage_skid.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_skid_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int COUNT_W = 16
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_result;
    logic [ADDR_W-1:0]  in_addr;
    logic               in_we;
    logic               wb_valid;
    logic               wb_ready;
    logic               wb_we;
    logic [DATA_W-1:0]  wb_result;
    logic [ADDR_W-1:0]  wb_addr;
    logic [ADDR_W-1:0]  fwd_addr;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic [COUNT_W-1:0] retire_count;

    modport master (
        output flush, in_valid, in_result, in_addr, in_we, wb_ready, fwd_addr,
        input  in_ready, wb_valid, wb_we, wb_result, wb_addr, fwd_hit, fwd_data,
               retire_count
    );

    modport slave (
        input  flush, in_valid, in_result, in_addr, in_we, wb_ready, fwd_addr,
        output in_ready, wb_valid, wb_we, wb_result, wb_addr, fwd_hit, fwd_data,
               retire_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_skid
// Brief    : Writeback stage with 2-entry skid buffer, flush, r0 guard,
//            forwarding lookup and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_skid #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int ZERO_REG_RO = 1,
    parameter int COUNT_W     = 16
) (
    input  wire              clk,
    input  wire              reset,
    wb_stage_skid_if.slave   bus
);
    localparam logic c_ro_zero = (ZERO_REG_RO != 0);

    logic               r_head_v, r_head_we, r_skid_v, r_skid_we;
    logic [DATA_W-1:0]  r_head_data, r_skid_data;
    logic [ADDR_W-1:0]  r_head_addr, r_skid_addr;
    logic [COUNT_W-1:0] r_retire_count;

    logic w_accept, w_fire;
    logic w_head_zero, w_skid_zero;
    logic w_head_match, w_skid_match;

    // in_ready depends on registered state only, breaking the wb_ready path
    assign bus.in_ready = !r_skid_v;
    assign w_accept     = bus.in_valid && !r_skid_v && !bus.flush;
    assign w_fire       = r_head_v && bus.wb_ready && !bus.flush;

    assign w_head_zero  = c_ro_zero && (r_head_addr == '0);
    assign w_skid_zero  = c_ro_zero && (r_skid_addr == '0);

    assign bus.wb_valid     = r_head_v;
    assign bus.wb_result    = r_head_data;
    assign bus.wb_addr      = r_head_addr;
    assign bus.wb_we        = r_head_v && r_head_we && !bus.flush && !w_head_zero;
    assign bus.retire_count = r_retire_count;

    assign w_skid_match = r_skid_v && r_skid_we && (r_skid_addr == bus.fwd_addr) && !w_skid_zero;
    assign w_head_match = r_head_v && r_head_we && (r_head_addr == bus.fwd_addr) && !w_head_zero;

    always_comb begin
        bus.fwd_hit  = w_skid_match || w_head_match;
        bus.fwd_data = '0;
        if (w_skid_match)
            bus.fwd_data = r_skid_data;
        else if (w_head_match)
            bus.fwd_data = r_head_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_v       <= 1'b0;
            r_head_we      <= 1'b0;
            r_head_data    <= '0;
            r_head_addr    <= '0;
            r_skid_v       <= 1'b0;
            r_skid_we      <= 1'b0;
            r_skid_data    <= '0;
            r_skid_addr    <= '0;
            r_retire_count <= '0;
        end else if (bus.flush) begin
            r_head_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            if (w_fire)
                r_retire_count <= r_retire_count + COUNT_W'(1);

            if (!r_head_v) begin
                if (w_accept) begin
                    r_head_v    <= 1'b1;
                    r_head_data <= bus.in_result;
                    r_head_addr <= bus.in_addr;
                    r_head_we   <= bus.in_we;
                end
            end else if (w_fire) begin
                if (r_skid_v) begin
                    // skid promotes to head; skid refills from input if accepted
                    r_head_data <= r_skid_data;
                    r_head_addr <= r_skid_addr;
                    r_head_we   <= r_skid_we;
                    r_skid_v    <= w_accept;
                    if (w_accept) begin
                        r_skid_data <= bus.in_result;
                        r_skid_addr <= bus.in_addr;
                        r_skid_we   <= bus.in_we;
                    end
                end else if (w_accept) begin
                    r_head_data <= bus.in_result;
                    r_head_addr <= bus.in_addr;
                    r_head_we   <= bus.in_we;
                end else begin
                    r_head_v <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_v    <= 1'b1;
                r_skid_data <= bus.in_result;
                r_skid_addr <= bus.in_addr;
                r_skid_we   <= bus.in_we;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_skid
// Brief    : Directed self-checking bench for wb_stage_skid (COUNT_W=4 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_skid;
    localparam int c_data_w  = 16;
    localparam int c_addr_w  = 3;
    localparam int c_count_w = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    wb_stage_skid_if #(.DATA_W(c_data_w), .ADDR_W(c_addr_w), .COUNT_W(c_count_w)) bus ();

    wb_stage_skid #(
        .DATA_W(c_data_w), .ADDR_W(c_addr_w), .ZERO_REG_RO(1), .COUNT_W(c_count_w)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] a, input logic we);
        bus.in_valid  = v;
        bus.in_result = d;
        bus.in_addr   = a;
        bus.in_we     = we;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 16'hAAAA, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin
                reset = 1'b0;
                drive(1'b0, 16'h0, 3'd0, 1'b0);
            end
            vectors++;
            if (bus.wb_valid !== 1'b0 || bus.wb_we !== 1'b0 || bus.in_ready !== 1'b1 ||
                bus.retire_count !== 4'd0 || bus.wb_result !== 16'h0 || bus.wb_addr !== 3'd0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got v=%b we=%b rdy=%b cnt=%0d res=%h addr=%0d, want 0 0 1 0 0000 0",
                         i, bus.wb_valid, bus.wb_we, bus.in_ready, bus.retire_count, bus.wb_result, bus.wb_addr);
            end
        end
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.retire_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_after: got v=%b rdy=%b cnt=%0d, want 0 1 0",
                     bus.wb_valid, bus.in_ready, bus.retire_count);
        end
    endtask

    task automatic test_streaming();
        bus.wb_ready = 1'b1;
        drive(1'b1, 16'h1234, 3'd3, 1'b1);
        tick();
        drive(1'b1, 16'hBEEF, 3'd5, 1'b1);
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b1 || bus.wb_result !== 16'h1234 || bus.wb_addr !== 3'd3) begin
            miscompares++;
            $display("FAIL stream_a: got v=%b we=%b res=%h addr=%0d, want 1 1 1234 3",
                     bus.wb_valid, bus.wb_we, bus.wb_result, bus.wb_addr);
        end
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_result !== 16'hBEEF || bus.wb_addr !== 3'd5) begin
            miscompares++;
            $display("FAIL stream_b: got v=%b res=%h addr=%0d, want 1 beef 5",
                     bus.wb_valid, bus.wb_result, bus.wb_addr);
        end
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.retire_count !== 4'd2) begin
            miscompares++;
            $display("FAIL stream_done: got v=%b cnt=%0d, want 0 2", bus.wb_valid, bus.retire_count);
        end
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'h0A0A, 3'd1, 1'b1);
        tick();
        drive(1'b1, 16'h0B0B, 3'd2, 1'b1);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_rdy_one: got in_ready=%b, want 1", bus.in_ready);
        end
        tick();
        drive(1'b1, 16'h0C0C, 3'd4, 1'b1);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.wb_result !== 16'h0A0A) begin
            miscompares++;
            $display("FAIL bp_full: got in_ready=%b res=%h, want 0 0a0a", bus.in_ready, bus.wb_result);
        end
        tick();
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_result !== 16'h0A0A) begin
            miscompares++;
            $display("FAIL bp_hold: got in_ready=%b v=%b res=%h, want 0 1 0a0a",
                     bus.in_ready, bus.wb_valid, bus.wb_result);
        end
        bus.wb_ready = 1'b1;
        tick();
        vectors++;
        if (bus.wb_result !== 16'h0B0B || bus.wb_addr !== 3'd2 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_b: got res=%h addr=%0d rdy=%b, want 0b0b 2 1",
                     bus.wb_result, bus.wb_addr, bus.in_ready);
        end
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_result !== 16'h0C0C || bus.wb_addr !== 3'd4) begin
            miscompares++;
            $display("FAIL bp_c: got v=%b res=%h addr=%0d, want 1 0c0c 4",
                     bus.wb_valid, bus.wb_result, bus.wb_addr);
        end
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.retire_count !== 4'd5) begin
            miscompares++;
            $display("FAIL bp_done: got v=%b cnt=%0d, want 0 5", bus.wb_valid, bus.retire_count);
        end
    endtask

    task automatic test_flush();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'h5555, 3'd5, 1'b1);
        tick();
        drive(1'b1, 16'h6666, 3'd6, 1'b1);
        tick();
        bus.wb_ready = 1'b1;
        bus.flush    = 1'b1;
        drive(1'b1, 16'h7777, 3'd7, 1'b1);
        vectors++;
        if (bus.wb_we !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_we_gate: got wb_we=%b, want 0", bus.wb_we);
        end
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.retire_count !== 4'd5) begin
            miscompares++;
            $display("FAIL flush_full: got v=%b rdy=%b cnt=%0d, want 0 1 5",
                     bus.wb_valid, bus.in_ready, bus.retire_count);
        end
        bus.flush = 1'b1;
        drive(1'b1, 16'h7777, 3'd7, 1'b1);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.retire_count !== 4'd5) begin
            miscompares++;
            $display("FAIL flush_input: got v=%b cnt=%0d, want 0 5", bus.wb_valid, bus.retire_count);
        end
    endtask

    task automatic test_forwarding();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'h1111, 3'd2, 1'b1);
        tick();
        drive(1'b1, 16'h2222, 3'd2, 1'b1);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        bus.fwd_addr = 3'd2;
        #1;
        vectors++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222) begin
            miscompares++;
            $display("FAIL fwd_youngest: got hit=%b data=%h, want 1 2222", bus.fwd_hit, bus.fwd_data);
        end
        bus.fwd_addr = 3'd3;
        #1;
        vectors++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 16'h0) begin
            miscompares++;
            $display("FAIL fwd_miss: got hit=%b data=%h, want 0 0000", bus.fwd_hit, bus.fwd_data);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        bus.fwd_addr = 3'd2;
        #1;
        vectors++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 16'h2222 || bus.retire_count !== 4'd6) begin
            miscompares++;
            $display("FAIL fwd_head: got hit=%b data=%h cnt=%0d, want 1 2222 6",
                     bus.fwd_hit, bus.fwd_data, bus.retire_count);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 3'd0, 1'b1);
        tick();
        drive(1'b1, 16'h3333, 3'd3, 1'b0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        bus.fwd_addr = 3'd0;
        #1;
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0 || bus.fwd_hit !== 1'b0 || bus.wb_result !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL r0_guard: got v=%b we=%b hit=%b res=%h, want 1 0 0 ffff",
                     bus.wb_valid, bus.wb_we, bus.fwd_hit, bus.wb_result);
        end
        bus.fwd_addr = 3'd3;
        #1;
        vectors++;
        if (bus.fwd_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_no_we: got hit=%b, want 0", bus.fwd_hit);
        end
        bus.wb_ready = 1'b1;
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0 || bus.wb_result !== 16'h3333 || bus.retire_count !== 4'd8) begin
            miscompares++;
            $display("FAIL no_we_entry: got v=%b we=%b res=%h cnt=%0d, want 1 0 3333 8",
                     bus.wb_valid, bus.wb_we, bus.wb_result, bus.retire_count);
        end
        tick();
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.retire_count !== 4'd9) begin
            miscompares++;
            $display("FAIL fwd_done: got v=%b cnt=%0d, want 0 9", bus.wb_valid, bus.retire_count);
        end
    endtask

    task automatic test_counter_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 16'(i), 3'd1, 1'b1);
            tick();
        end
        vectors++;
        if (bus.retire_count !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_16: got cnt=%0d, want 0", bus.retire_count);
        end
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        tick();
        vectors++;
        if (bus.retire_count !== 4'd1 || bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_17: got cnt=%0d v=%b, want 1 0", bus.retire_count, bus.wb_valid);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_addr  = '0;
        bus.in_we    = 1'b0;
        bus.wb_ready = 1'b0;
        bus.fwd_addr = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
